f_pc_redirect: RTL

//  Fetch-stage PC register that consumes the Decode-stage combined "jump" request (branch taken | j | jal | jr)
//  and its resolved target. Holds PC under hazard stall and buffers a redirect that arrives during a stall.

---
 rtl/f_pc_redirect.sv | 103 ++++++++++
 1 files changed

// File: rtl/f_pc_redirect.sv
// Fetch-stage PC register with stall hold and a one-entry redirect buffer.
// A redirect (taken branch, j, jal or jr) from Decode that arrives while the
// hazard unit stalls is remembered and applied on the first non-stalled edge.
// Also produces the PC+4 link value, a fetch-address fault flag and a
// saturating count of applied redirects.
//
// Control semantics (there is no valid/ready pair here):
//   jump/jump_target act as a valid/payload pair. Decode presents the pair for
//   exactly one cycle and expects no acknowledgement. stall acts as an inverted
//   ready. When stall=0 a live jump is applied at that edge. When stall=1 the
//   target is captured into the buffer, and a later jump in the same stall
//   overwrites it. The buffered target is applied on the first edge with
//   stall=0, unless a live jump on that same edge replaces it.
module f_pc_redirect #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] IMEM_BASE = 32'h0000_3000,
  parameter logic [31:0] IMEM_SIZE = 32'h0000_4000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             jump,
  input  logic [31:0]      jump_target,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             pc_adel,
  output logic             redirect_pending,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  // The legal window is computed in 33 bits so that IMEM_BASE+IMEM_SIZE = 2^32
  // cannot wrap around.
  localparam logic [32:0] WIN_LO = {1'b0, IMEM_BASE};
  localparam logic [32:0] WIN_HI = {1'b0, IMEM_BASE} + {1'b0, IMEM_SIZE};

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pend_tgt_q, pend_tgt_d;
  logic [CNT_W-1:0] cnt_q;
  logic             apply_redirect;
  logic [31:0]      seq_pc;

  assign seq_pc = pc_q + 32'd4;

  // State register: PC, buffer FSM, buffered target and redirect counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      pend_tgt_q <= 32'h0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      if (apply_redirect && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Next-state logic, in priority order: stall, live jump, buffered redirect, sequential.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    pend_tgt_d     = pend_tgt_q;
    apply_redirect = 1'b0;
    if (stall) begin
      if (jump) begin
        pend_tgt_d = jump_target;
        state_d    = PEND;
      end
    end else if (jump) begin
      pc_d           = jump_target;
      state_d        = IDLE;
      apply_redirect = 1'b1;
    end else if (state_q == PEND) begin
      pc_d           = pend_tgt_q;
      state_d        = IDLE;
      apply_redirect = 1'b1;
    end else begin
      pc_d = seq_pc;
    end
  end

  // Outputs: registered PC and counter, plus combinational link value and fault flag.
  always_comb begin
    pc               = pc_q;
    pc_plus4         = seq_pc;
    redirect_pending = (state_q == PEND);
    redirect_cnt     = cnt_q;
    pc_adel          = (pc_q[1:0] != 2'b00) ||
                       ({1'b0, pc_q} < WIN_LO) ||
                       ({1'b0, pc_q} >= WIN_HI);
  end

endmodule
